mem8x16_ctrl: RTL and testbench

//  Two-port access controller for the 7-row x 16-bit register memory (rows 0..6, address 7 unbacked).

---
 rtl/mem8x16_pkg.sv | 24 ++
 rtl/mem8x16_ctrl_if.sv | 52 +++++
 rtl/mem8x16_ctrl_rr_arb2.sv | 34 +++
 rtl/mem8x16_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem8x16_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mem8x16_pkg.sv
// Shared constants, FSM state type and address helper for the 7-row x 16-bit memory controller.
package mem8x16_pkg;

  localparam int unsigned DW       = 16;
  localparam int unsigned AW       = 3;
  localparam int unsigned NUM_ROWS = 7;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_CAPT,
    ST_RESP,
    ST_CLEAR
  } state_e;

  function automatic logic row_valid(input logic [AW-1:0] addr);
    return 32'(addr) < NUM_ROWS;
  endfunction

endpackage

// File: rtl/mem8x16_ctrl_if.sv
// Request/response bus for ports A and B, clear request, and the controlled memory pins.
interface mem8x16_ctrl_if;
  import mem8x16_pkg::*;

  logic          a_valid;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ready;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          a_err;

  logic          b_valid;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ready;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;
  logic          b_err;

  logic          clr;

  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          mem_rst;

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata, a_err,
    input  b_valid, b_we, b_addr, b_wdata,
    output b_ready, b_rvalid, b_rdata, b_err,
    input  clr,
    output mem_cs, mem_we, mem_addr, mem_din, mem_rst,
    input  mem_dout
  );

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata, a_err,
    output b_valid, b_we, b_addr, b_wdata,
    input  b_ready, b_rvalid, b_rdata, b_err,
    output clr,
    input  mem_cs, mem_we, mem_addr, mem_din, mem_rst,
    output mem_dout
  );

endinterface

// File: rtl/mem8x16_ctrl_rr_arb2.sv
// Two-way arbiter: round-robin on ties, or port A always wins ties when FIXED_PRI is set.
module rr_arb2 import mem8x16_pkg::*; #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (FIXED_PRI || last_q == PORT_B) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (accept) last_d = gnt[1] ? PORT_B : PORT_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PORT_B;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mem8x16_ctrl.sv
// Two-port access sequencer for the 7-row register memory: arbitrates A/B, phases each access
// so the row clock only rises on stable addr/din, and issues a one-cycle memory clear.
module mem8x16_ctrl import mem8x16_pkg::*; #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  mem8x16_ctrl_if.slave  bus
);

  state_e        state_q, state_d;
  logic          clr_pend_q, clr_pend_d;
  logic          clear_q, clear_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic          mem_cs_q, mem_cs_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic          a_err_q, a_err_d, b_err_q, b_err_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic [1:0]    req, gnt;
  logic          accept;
  logic          sel_port, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          rsp_valid, rsp_port, rsp_err;
  logic [DW-1:0] rsp_data;

  assign req = {bus.b_valid, bus.a_valid};

  rr_arb2 #(.FIXED_PRI(FIXED_PRI)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign sel_port  = gnt[1] ? PORT_B : PORT_A;
  assign sel_we    = gnt[1] ? bus.b_we    : bus.a_we;
  assign sel_addr  = gnt[1] ? bus.b_addr  : bus.a_addr;
  assign sel_wdata = gnt[1] ? bus.b_wdata : bus.a_wdata;

  always_comb begin
    state_d    = state_q;
    clr_pend_d = clr_pend_q | bus.clr;
    clear_d    = 1'b0;
    port_d     = port_q;
    we_d       = we_q;
    mem_cs_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    accept     = 1'b0;
    rsp_valid  = 1'b0;
    rsp_port   = port_q;
    rsp_err    = 1'b0;
    rsp_data   = '0;

    case (state_q)
      ST_IDLE: begin
        if (clr_pend_q) begin
          state_d = ST_CLEAR;
          clear_d = 1'b1;
        end else if (rst_n && (|req)) begin
          accept = 1'b1;
          port_d = sel_port;
          we_d   = sel_we;
          if (!row_valid(sel_addr)) begin
            state_d   = ST_RESP;
            rsp_valid = 1'b1;
            rsp_port  = sel_port;
            rsp_err   = 1'b1;
          end else begin
            // Reads raise cs already in SETUP; writes hold cs low until addr/din have settled.
            state_d    = ST_SETUP;
            mem_addr_d = sel_addr;
            mem_din_d  = sel_wdata;
            mem_cs_d   = ~sel_we;
          end
        end
      end
      ST_SETUP: begin
        mem_cs_d = 1'b1;
        mem_we_d = we_q;
        state_d  = we_q ? ST_STROBE : ST_CAPT;
      end
      ST_STROBE: begin
        state_d   = ST_RESP;
        rsp_valid = 1'b1;
      end
      ST_CAPT: begin
        state_d   = ST_RESP;
        rsp_valid = 1'b1;
        rsp_data  = bus.mem_dout;
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_CLEAR: begin
        state_d    = ST_IDLE;
        clr_pend_d = bus.clr;
      end
      default:  state_d = ST_IDLE;
    endcase

    a_rvalid_d = rsp_valid & (rsp_port == PORT_A);
    b_rvalid_d = rsp_valid & (rsp_port == PORT_B);
    a_err_d    = a_rvalid_d & rsp_err;
    b_err_d    = b_rvalid_d & rsp_err;
    a_rdata_d  = a_rvalid_d ? rsp_data : '0;
    b_rdata_d  = b_rvalid_d ? rsp_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      clr_pend_q <= 1'b0;
      clear_q    <= 1'b0;
      port_q     <= PORT_A;
      we_q       <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      clear_q    <= clear_d;
      port_q     <= port_d;
      we_q       <= we_d;
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign bus.a_ready  = accept & (sel_port == PORT_A);
  assign bus.b_ready  = accept & (sel_port == PORT_B);
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_err    = a_err_q;
  assign bus.b_err    = b_err_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.mem_cs   = mem_cs_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_rst  = ~rst_n | clear_q;

endmodule

// File: tb/tb_mem8x16_ctrl.sv
// Directed plus random checks of mem8x16_ctrl against a transaction-level memory model.
module tb_mem8x16_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem8x16_ctrl_if bif();
  mem8x16_ctrl_if fif();

  mem8x16_ctrl #(.FIXED_PRI(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  mem8x16_ctrl #(.FIXED_PRI(1'b1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(fif));

  // Physical memory seen by the main DUT: writes on cs&we, clear on mem_rst.
  logic [15:0] rows [0:7];
  always @(posedge clk) begin
    if (bif.mem_rst) begin
      for (int i = 0; i < 8; i++) rows[i] <= '0;
    end else if (bif.mem_cs && bif.mem_we && bif.mem_addr != 3'd7) begin
      rows[bif.mem_addr] <= bif.mem_din;
    end
  end
  assign bif.mem_dout = rows[bif.mem_addr];
  assign fif.mem_dout = '0;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_mem [0:7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit port, input bit we, input logic [2:0] addr, input logic [15:0] wd,
                        input int clr_at, output int wait_c, output int lat, output logic [15:0] rd,
                        output logic err, output int cswe, output int cs_cnt, output bit orv,
                        output bit wnc);
    bit got;
    wait_c = -1; lat = -1; rd = 'x; err = 'x; cswe = -1; cs_cnt = 0; orv = 1'b0; wnc = 1'b0;
    got = 1'b0;
    @(posedge clk); #1;
    if (port == 1'b0) begin
      bif.a_valid = 1'b1; bif.a_we = we; bif.a_addr = addr; bif.a_wdata = wd;
    end else begin
      bif.b_valid = 1'b1; bif.b_we = we; bif.b_addr = addr; bif.b_wdata = wd;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      #1;
      if ((port == 1'b0) ? bif.a_ready : bif.b_ready) begin
        got = 1'b1;
        wait_c = i;
      end
    end
    for (int k = 1; k <= 10 && got; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin bif.a_valid = 1'b0; bif.b_valid = 1'b0; end
      bif.clr = (k == clr_at);
      #1;
      if (bif.mem_cs) cs_cnt++;
      if (bif.mem_cs && bif.mem_we && cswe < 0) cswe = k;
      if (bif.mem_we && !bif.mem_cs) wnc = 1'b1;
      if ((port == 1'b0) ? bif.b_rvalid : bif.a_rvalid) orv = 1'b1;
      if ((port == 1'b0) ? bif.a_rvalid : bif.b_rvalid) begin
        lat = k;
        rd  = (port == 1'b0) ? bif.a_rdata : bif.b_rdata;
        err = (port == 1'b0) ? bif.a_err : bif.b_err;
        break;
      end
    end
    bif.a_valid = 1'b0;
    bif.b_valid = 1'b0;
    bif.clr = 1'b0;
  endtask

  task automatic model_access(input bit port, input bit we, input logic [2:0] addr,
                              input logic [15:0] wd, input string tag);
    int wait_c, lat, cswe, cs_cnt;
    logic [15:0] rd;
    logic err;
    bit orv, wnc, bad;
    bad = (int'(addr) >= 7);
    access(port, we, addr, wd, -1, wait_c, lat, rd, err, cswe, cs_cnt, orv, wnc);
    check({tag, ".wait"},  wait_c, 0);
    check({tag, ".lat"},   lat, bad ? 1 : 3);
    check({tag, ".rdata"}, {16'h0, rd}, (we || bad) ? 32'h0 : {16'h0, exp_mem[addr]});
    check({tag, ".err"},   {31'h0, err}, {31'h0, bad});
    check({tag, ".cs"},    cs_cnt, bad ? 0 : (we ? 1 : 2));
    check({tag, ".cswe"},  cswe, (we && !bad) ? 2 : -1);
    check({tag, ".other"}, {31'h0, orv}, 32'h0);
    check({tag, ".wenocs"}, {31'h0, wnc}, 32'h0);
    if (we && !bad) exp_mem[addr] = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wait_c, lat, cswe, cs_cnt, cnt;
    logic [15:0] rd;
    logic err;
    bit orv, wnc, rvseen;
    int qm[$];
    int qf[$];

    bif.a_valid = 0; bif.a_we = 0; bif.a_addr = '0; bif.a_wdata = '0;
    bif.b_valid = 0; bif.b_we = 0; bif.b_addr = '0; bif.b_wdata = '0; bif.clr = 0;
    fif.a_valid = 0; fif.a_we = 0; fif.a_addr = '0; fif.a_wdata = '0;
    fif.b_valid = 0; fif.b_we = 0; fif.b_addr = '0; fif.b_wdata = '0; fif.clr = 0;
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;

    repeat (3) @(posedge clk);
    #2;
    check("rst.ready",  {31'h0, bif.a_ready}, 32'h0);
    check("rst.rvalid", {30'h0, bif.a_rvalid, bif.b_rvalid}, 32'h0);
    check("rst.rdata",  {16'h0, bif.a_rdata}, 32'h0);
    check("rst.cswe",   {30'h0, bif.mem_cs, bif.mem_we}, 32'h0);
    check("rst.addr",   {29'h0, bif.mem_addr}, 32'h0);
    check("rst.din",    {16'h0, bif.mem_din}, 32'h0);
    check("rst.memrst", {31'h0, bif.mem_rst}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rel.memrst", {31'h0, bif.mem_rst}, 32'h0);

    model_access(1'b0, 1'b1, 3'd2, 16'hBEEF, "wr2");
    model_access(1'b0, 1'b0, 3'd2, 16'h0000, "rd2");
    model_access(1'b1, 1'b0, 3'd7, 16'h0000, "berr");

    // Both ports contend continuously on both DUTs; record grant order.
    @(posedge clk); #1;
    bif.a_valid = 1; bif.b_valid = 1; bif.a_we = 0; bif.b_we = 0; bif.a_addr = 3'd0; bif.b_addr = 3'd1;
    fif.a_valid = 1; fif.b_valid = 1;
    for (int i = 0; i < 40 && qm.size() < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      #1;
      if (bif.a_ready) qm.push_back(0);
      if (bif.b_ready) qm.push_back(1);
      if (fif.a_ready) qf.push_back(0);
      if (fif.b_ready) qf.push_back(1);
    end
    @(posedge clk); #1;
    bif.a_valid = 0; bif.b_valid = 0; fif.a_valid = 0; fif.b_valid = 0;
    repeat (3) @(posedge clk);
    check("arb.n",   qm.size(), 4);
    check("arbfp.n", qf.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("arb.g%0d", i),   (qm.size() > i) ? qm[i] : 9, i % 2);
      check($sformatf("arbfp.g%0d", i), (qf.size() > i) ? qf[i] : 9, 0);
    end

    // Clear requested while a write is strobing: write finishes, then one clear cycle.
    access(1'b0, 1'b1, 3'd2, 16'h1234, 2, wait_c, lat, rd, err, cswe, cs_cnt, orv, wnc);
    check("clrw.lat",  lat, 3);
    check("clrw.cswe", cswe, 2);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      if (bif.mem_rst) cnt++;
    end
    check("clr.pulses", cnt, 1);
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    model_access(1'b0, 1'b0, 3'd2, 16'h0000, "clr_rd");

    // Reset asserted while a read is capturing.
    model_access(1'b0, 1'b1, 3'd3, 16'hA5A5, "w3");
    @(posedge clk); #1;
    bif.a_valid = 1; bif.a_we = 0; bif.a_addr = 3'd3;
    #1;
    check("ra.ready", {31'h0, bif.a_ready}, 32'h1);
    @(posedge clk); #1;
    bif.a_valid = 0;
    @(posedge clk); #2;
    check("ra.capt_cs", {31'h0, bif.mem_cs}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("ra.cs",     {30'h0, bif.mem_cs, bif.mem_we}, 32'h0);
    check("ra.memrst", {31'h0, bif.mem_rst}, 32'h1);
    check("ra.rvalid", {30'h0, bif.a_rvalid, bif.b_rvalid}, 32'h0);
    check("ra.addr",   {29'h0, bif.mem_addr}, 32'h0);
    rvseen = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
      if (bif.a_rvalid || bif.b_rvalid) rvseen = 1'b1;
    end
    check("ra.norsp", {31'h0, rvseen}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    model_access(1'b0, 1'b0, 3'd3, 16'h0000, "post_rst");

    for (int n = 0; n < 24; n++) begin
      model_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 16'($urandom), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
